main_memory_pipe: RTL and testbench
===================================

MAIN_MEMORY_PIPE -- requirements
Module: main_memory_pipe

Interface
REQ-001 Parameter add_width, default 12, word-address width.
REQ-002 Parameter data_width, default 32, word width; SHALL be a multiple of 8.
REQ-003 Parameter mem_depth, default 4096, words implemented; SHALL be <= 2**add_width.
REQ-004 Parameter latency, default 2, cycles from accept to ready; SHALL be >= 1.
REQ-005 clk  input  1  clock; all logic on posedge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 add  input  add_width  word address.
REQ-008 write_data  input  data_width  write data.
REQ-009 byte_en  input  data_width/8  write byte strobes; bit i enables bits [8i+7:8i].
REQ-010 mem_read  input  1  read request.
REQ-011 mem_write  input  1  write request.
REQ-012 read_data  output  data_width  read result.
REQ-013 ready  output  1  one-cycle completion pulse.
REQ-014 busy  output  1  high while not accepting requests.
REQ-015 err  output  1  error flag, valid with ready.

Function
REQ-016 FSM states: INIT, IDLE, BUSY.
REQ-017 INIT: write 0 to one word per cycle, index 0 to mem_depth-1, then go to IDLE; busy=1 throughout.
REQ-018 IDLE: busy=0; a request is accepted on a posedge where mem_read or mem_write is 1; add, write_data, byte_en and the request type are captured; go to BUSY.
REQ-019 If mem_read and mem_write are both 1, the request is a write.
REQ-020 BUSY: busy=1; a counter loaded with latency-1 on accept decrements each cycle; mem_read/mem_write are ignored.
REQ-021 Completion occurs on the cycle the counter reads 0: the write updates only enabled bytes, or the read loads read_data; ready=1 for exactly that following cycle; FSM returns to IDLE.
REQ-022 With latency=1, ready asserts the cycle after accept, and a new request is acceptable on the cycle ready is high.
REQ-023 read_data holds its value until the next read completes; writes do not change it.
REQ-024 A write with byte_en all zero completes normally with ready=1 and memory unchanged.
REQ-025 A read completing in the cycle after a write to the same address returns the updated data.
REQ-026 ready=0 in every cycle other than a completion cycle.

Reset
REQ-027 While reset=0: state=INIT, init index=0, latency counter=0, ready=0, read_data=0, err=0, busy=1.
REQ-028 Reset asserted mid-access aborts the access with no memory update and restarts INIT after release.
REQ-029 Memory contents are cleared only by INIT, not combinationally by reset.

Configuration
REQ-030 Macro MEM_RANGE_CHECK_EN compiled in: an access with add >= mem_depth does not touch memory, completes with the normal latency with ready=1 and err=1, and leaves read_data unchanged for reads; err=0 for all other completions.
REQ-031 Without MEM_RANGE_CHECK_EN: err is tied to 0 and out-of-range addresses index memory modulo the implemented array (no guard logic).

Structure
REQ-032 Shared package mem_pkg holds the FSM state typedef (INIT/IDLE/BUSY) and the default parameter constants.
REQ-033 The latency countdown is the sub-module mem_lat_counter (load, decrement, zero flag).

Verification
REQ-034 Release reset and count cycles -> busy=1 for mem_depth cycles, then busy=0; a read of add 0x7FF returns 0.
REQ-035 Latency=2: write 0xDEADBEEF to add 0x010 with byte_en=4'hF, then read 0x010 -> ready appears 2 cycles after each accept; read_data=0xDEADBEEF.
REQ-036 Write 0x000000AA with byte_en=4'h1 over 0x11223344 -> read returns 0x112233AA.
REQ-037 Drive mem_read and mem_write together at 0x020 with data 0x5 -> treated as a write; a later read returns 0x5; read_data unchanged at write completion.
REQ-038 Assert reset during BUSY of a write to 0x030 -> ready never pulses; after INIT, a read of 0x030 returns 0.
REQ-039 With MEM_RANGE_CHECK_EN, add_width=12, mem_depth=1024, read 0x400 -> ready=1, err=1, read_data unchanged; without the macro, err stays 0.

Source files
------------

// File: rtl/mem_pkg.sv
// ============================================================================
//  Module   : mem_pkg
//  Purpose  : Shared definitions for the main_memory_pipe slice: FSM state
//             encoding, default parameter values and a small width helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_pkg;

   localparam int c_ADD_WIDTH  = 12;
   localparam int c_DATA_WIDTH = 32;
   localparam int c_MEM_DEPTH  = 4096;
   localparam int c_LATENCY    = 2;

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_IDLE = 2'd1,
      ST_BUSY = 2'd2
   } state_t;

   // Bits needed to hold values 0..n-1, never less than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lat_counter.sv
// ============================================================================
//  Module   : mem_lat_counter
//  Purpose  : Access latency countdown. Loaded when a request is accepted,
//             decrements while enabled and saturates at zero.
//  Ports    : clk, reset (async, active-low)
//             load / load_val : load the countdown value
//             dec             : decrement enable
//             zero            : count currently reads zero
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_lat_counter
   import mem_pkg::*;
#(
   parameter int WIDTH = cnt_width(c_LATENCY)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= load_val;
      end else if (dec && (r_count != '0)) begin
         r_count <= r_count - WIDTH'(1);
      end
   end

   assign zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/main_memory_pipe.sv
// ============================================================================
//  Module   : main_memory_pipe
//  Purpose  : Single-port word memory with a fixed access latency. After
//             reset the whole array is zeroed one word per cycle (INIT),
//             then single read/write requests are served with a one-cycle
//             ready pulse after 'latency' cycles.
//  Ports    : clk, reset (async, active-low)
//             add, write_data, byte_en, mem_read, mem_write : request side
//             read_data, ready, busy, err                    : response side
//  Options  : MEM_RANGE_CHECK_EN - when defined, accesses with add >= mem_depth
//             leave memory and read_data untouched and complete with err=1.
//             When undefined, err is 0 and addresses wrap modulo mem_depth.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module main_memory_pipe
   import mem_pkg::*;
#(
   parameter int add_width  = c_ADD_WIDTH,
   parameter int data_width = c_DATA_WIDTH,
   parameter int mem_depth  = c_MEM_DEPTH,
   parameter int latency    = c_LATENCY
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [add_width-1:0]    add,
   input  logic [data_width-1:0]   write_data,
   input  logic [data_width/8-1:0] byte_en,
   input  logic                    mem_read,
   input  logic                    mem_write,
   output logic [data_width-1:0]   read_data,
   output logic                    ready,
   output logic                    busy,
   output logic                    err
);

   localparam int                   c_BE_W      = data_width / 8;
   localparam int                   c_IDX_W     = cnt_width(mem_depth);
   localparam int                   c_CNT_W     = cnt_width(latency);
   localparam logic [c_IDX_W-1:0]   c_LAST_IDX  = c_IDX_W'(mem_depth - 1);
   localparam logic [c_CNT_W-1:0]   c_CNT_LOAD  = c_CNT_W'(latency - 1);
   localparam logic [add_width:0]   c_DEPTH_EXT = (add_width + 1)'(mem_depth);

   state_t                  r_state;
   logic [c_IDX_W-1:0]      r_init_idx;
   logic [add_width-1:0]    r_add;
   logic [data_width-1:0]   r_wdata;
   logic [c_BE_W-1:0]       r_be;
   logic                    r_is_write;
   logic [data_width-1:0]   r_read_data;
   logic                    r_ready;
   logic [data_width-1:0]   r_mem [mem_depth];

   logic                    w_accept;
   logic                    w_cnt_zero;
   logic                    w_complete;
   logic                    w_in_range;
   logic [c_IDX_W-1:0]      w_word_idx;
   logic                    w_mem_we;
   logic [c_IDX_W-1:0]      w_mem_idx;
   logic [data_width-1:0]   w_mem_wdata;
   logic [c_BE_W-1:0]       w_mem_be;

   assign w_accept   = (r_state == ST_IDLE) && (mem_read || mem_write);
   assign w_complete = (r_state == ST_BUSY) && w_cnt_zero;

   // Extra MSB keeps the modulus representable when mem_depth == 2**add_width.
   assign w_word_idx = c_IDX_W'({1'b0, r_add} % c_DEPTH_EXT);

`ifdef MEM_RANGE_CHECK_EN
   assign w_in_range = ({1'b0, r_add} < c_DEPTH_EXT);
`else
   assign w_in_range = 1'b1;
`endif

   mem_lat_counter #(
      .WIDTH    (c_CNT_W)
   ) u_lat_counter (
      .clk      (clk),
      .reset    (reset),
      .load     (w_accept),
      .load_val (c_CNT_LOAD),
      .dec      (r_state == ST_BUSY),
      .zero     (w_cnt_zero)
   );

   // Single write port shared by the INIT sweep and request writes. Gated by
   // reset so that clock edges seen while reset is low never touch the array.
   always_comb begin
      w_mem_we    = 1'b0;
      w_mem_idx   = w_word_idx;
      w_mem_wdata = r_wdata;
      w_mem_be    = r_be;
      if (reset) begin
         if (r_state == ST_INIT) begin
            w_mem_we    = 1'b1;
            w_mem_idx   = r_init_idx;
            w_mem_wdata = '0;
            w_mem_be    = '1;
         end else if (w_complete && r_is_write && w_in_range) begin
            w_mem_we    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         for (int b = 0; b < c_BE_W; b++) begin
            if (w_mem_be[b]) begin
               r_mem[w_mem_idx][8*b +: 8] <= w_mem_wdata[8*b +: 8];
            end
         end
      end
   end

`ifdef MEM_RANGE_CHECK_EN
   logic r_err;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_INIT;
         r_init_idx  <= '0;
         r_add       <= '0;
         r_wdata     <= '0;
         r_be        <= '0;
         r_is_write  <= 1'b0;
         r_read_data <= '0;
         r_ready     <= 1'b0;
`ifdef MEM_RANGE_CHECK_EN
         r_err       <= 1'b0;
`endif
      end else begin
         r_ready <= 1'b0;
`ifdef MEM_RANGE_CHECK_EN
         r_err   <= 1'b0;
`endif
         case (r_state)
            ST_INIT: begin
               if (r_init_idx == c_LAST_IDX) begin
                  r_init_idx <= '0;
                  r_state    <= ST_IDLE;
               end else begin
                  r_init_idx <= r_init_idx + c_IDX_W'(1);
               end
            end
            ST_IDLE: begin
               if (w_accept) begin
                  r_add      <= add;
                  r_wdata    <= write_data;
                  r_be       <= byte_en;
                  // A simultaneous read and write request is served as a write.
                  r_is_write <= mem_write;
                  r_state    <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (w_cnt_zero) begin
                  r_ready <= 1'b1;
                  r_state <= ST_IDLE;
                  if (!r_is_write && w_in_range) begin
                     r_read_data <= r_mem[w_word_idx];
                  end
`ifdef MEM_RANGE_CHECK_EN
                  r_err <= !w_in_range;
`endif
               end
            end
            default: r_state <= ST_INIT;
         endcase
      end
   end

   assign read_data = r_read_data;
   assign ready     = r_ready;
   assign busy      = (r_state != ST_IDLE);
`ifdef MEM_RANGE_CHECK_EN
   assign err       = r_err;
`else
   assign err       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_main_memory_pipe.sv
// ============================================================================
//  Module   : tb_main_memory_pipe
//  Purpose  : Directed self-checking bench for main_memory_pipe
//             (add_width=12, data_width=32, mem_depth=1024, latency=2).
//             Expected err / out-of-range results follow MEM_RANGE_CHECK_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_main_memory_pipe;

   localparam int AW    = 12;
   localparam int DW    = 32;
   localparam int DEPTH = 1024;
   localparam int LAT   = 2;

`ifdef MEM_RANGE_CHECK_EN
   localparam logic c_CHK = 1'b1;
`else
   localparam logic c_CHK = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset;
   logic [AW-1:0]   add;
   logic [DW-1:0]   write_data;
   logic [DW/8-1:0] byte_en;
   logic            mem_read;
   logic            mem_write;
   logic [DW-1:0]   read_data;
   logic            ready;
   logic            busy;
   logic            err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   main_memory_pipe #(
      .add_width  (AW),
      .data_width (DW),
      .mem_depth  (DEPTH),
      .latency    (LAT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .add        (add),
      .write_data (write_data),
      .byte_en    (byte_en),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .read_data  (read_data),
      .ready      (ready),
      .busy       (busy),
      .err        (err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   // Starts at a negedge with the DUT idle, ends at the negedge where ready is high.
   task automatic access(input string tag, input logic rd, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [DW/8-1:0] be);
      int n;
      add        = a;
      write_data = d;
      byte_en    = be;
      mem_read   = rd;
      mem_write  = wr;
      @(negedge clk);
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      n = 0;
      while (ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, " latency"}, n, LAT);
      check({tag, " busy_at_ready"}, {31'b0, busy}, 32'h0);
   endtask

   // Counts cycles with busy high from the current negedge; ready must stay low.
   task automatic wait_init(input string tag);
      int n;
      int pulses;
      n = 0;
      pulses = 0;
      while (busy !== 1'b0 && n < 3000) begin
         if (ready === 1'b1) pulses++;
         @(negedge clk);
         n++;
      end
      check({tag, " init_cycles"}, n, DEPTH);
      check({tag, " init_ready_pulses"}, pulses, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      reset      = 1'b0;
      add        = '0;
      write_data = '0;
      byte_en    = '0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;

      repeat (3) @(negedge clk);
      check("reset busy",      {31'b0, busy},  32'h1);
      check("reset ready",     {31'b0, ready}, 32'h0);
      check("reset err",       {31'b0, err},   32'h0);
      check("reset read_data", read_data,      32'h0);

      reset = 1'b1;
      wait_init("post_reset");

      // Fresh memory reads zero; 0x7FF is beyond the 1024-word array.
      access("rd_7ff", 1'b1, 1'b0, 12'h7FF, 32'h0, 4'h0);
      check("rd_7ff data", read_data, 32'h0);
      check("rd_7ff err",  {31'b0, err}, {31'b0, c_CHK});

      access("wr_010", 1'b0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF);
      check("wr_010 err",  {31'b0, err}, 32'h0);
      check("wr_010 read_data_held", read_data, 32'h0);
      access("rd_010", 1'b1, 1'b0, 12'h010, 32'h0, 4'h0);
      check("rd_010 data", read_data, 32'hDEADBEEF);
      check("rd_010 err",  {31'b0, err}, 32'h0);

      // Partial byte write merges into existing word.
      access("wr_011_full", 1'b0, 1'b1, 12'h011, 32'h11223344, 4'hF);
      access("wr_011_b0",   1'b0, 1'b1, 12'h011, 32'h000000AA, 4'h1);
      access("rd_011", 1'b1, 1'b0, 12'h011, 32'h0, 4'h0);
      check("rd_011 data", read_data, 32'h112233AA);

      // Read and write together act as a write; read_data untouched.
      access("rw_020", 1'b1, 1'b1, 12'h020, 32'h00000005, 4'hF);
      check("rw_020 read_data_held", read_data, 32'h112233AA);
      access("rd_020", 1'b1, 1'b0, 12'h020, 32'h0, 4'h0);
      check("rd_020 data", read_data, 32'h00000005);

      // Byte enables all zero: completes, memory unchanged.
      access("wr_020_nobe", 1'b0, 1'b1, 12'h020, 32'hFFFFFFFF, 4'h0);
      access("rd_020b", 1'b1, 1'b0, 12'h020, 32'h0, 4'h0);
      check("rd_020b data", read_data, 32'h00000005);

      // Out-of-range: guarded when checking is on, wraps to word 0 otherwise.
      access("rd_400", 1'b1, 1'b0, 12'h400, 32'h0, 4'h0);
      check("rd_400 err",  {31'b0, err}, {31'b0, c_CHK});
      check("rd_400 data", read_data, c_CHK ? 32'h00000005 : 32'h0);
      access("wr_405", 1'b0, 1'b1, 12'h405, 32'h00000077, 4'hF);
      check("wr_405 err",  {31'b0, err}, {31'b0, c_CHK});
      access("rd_005", 1'b1, 1'b0, 12'h005, 32'h0, 4'h0);
      check("rd_005 data", read_data, c_CHK ? 32'h0 : 32'h00000077);
      check("rd_005 err",  {31'b0, err}, 32'h0);

      // Reset while a write is in flight: aborted, INIT reruns.
      add        = 12'h030;
      write_data = 32'h12345678;
      byte_en    = 4'hF;
      mem_write  = 1'b1;
      @(negedge clk);
      mem_write  = 1'b0;
      check("abort busy_before", {31'b0, busy}, 32'h1);
      reset = 1'b0;
      #1;
      check("abort ready_in_reset", {31'b0, ready}, 32'h0);
      check("abort read_data_in_reset", read_data, 32'h0);
      repeat (3) @(negedge clk);
      check("abort ready_held_low", {31'b0, ready}, 32'h0);
      reset = 1'b1;
      wait_init("post_abort");
      access("rd_030", 1'b1, 1'b0, 12'h030, 32'h0, 4'h0);
      check("rd_030 data", read_data, 32'h0);
      access("rd_010_cleared", 1'b1, 1'b0, 12'h010, 32'h0, 4'h0);
      check("rd_010_cleared data", read_data, 32'h0);

      @(negedge clk);
      check("idle ready_low", {31'b0, ready}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
